// File: rtl/output_display.sv
// output_display
//
// Captures the CPU output-register byte on a rising edge of the output-enable
// strobe. A sequential double-dabble engine converts the byte to three BCD
// digits. The digits drive a multiplexed three-digit common-cathode 7-segment
// display, with leading-zero blanking.
//
// Ports:
//   fastClk  - single clock; all state updates on its rising edge
//   rst      - asynchronous active-low reset
//   load     - output-enable strobe (level); a rising edge triggers a capture
//   data_bus - CPU bus byte, sampled on a detected load rise
//   value    - last captured byte
//   busy     - high while a conversion (CONV or COMMIT) is in progress
//   seg      - segment drive {g,f,e,d,c,b,a}, active-high
//   dig_en   - one-hot digit enable: bit 0 ones, bit 1 tens, bit 2 hundreds
module output_display #(
   parameter int unsigned REFRESH_DIV = 1024
) (
   input  logic       fastClk,
   input  logic       rst,
   input  logic       load,
   input  logic [7:0] data_bus,
   output logic [7:0] value,
   output logic       busy,
   output logic [6:0] seg,
   output logic [2:0] dig_en
);

   typedef enum logic [1:0] {StIdle, StConv, StCommit} state_e;

   localparam logic [15:0] CntMax = 16'(REFRESH_DIV - 1);

   state_e      state_q, state_d;
   logic        load_q;
   logic [7:0]  value_q, value_d;
   logic [19:0] shift_q, shift_d;
   logic [2:0]  iter_q, iter_d;
   logic [1:0]  disp_hund_q, disp_hund_d;
   logic [3:0]  disp_tens_q, disp_tens_d;
   logic [3:0]  disp_ones_q, disp_ones_d;
   logic [15:0] refresh_cnt_q, refresh_cnt_d;
   logic [1:0]  idx_q, idx_d;
   logic [6:0]  seg_q, seg_d;
   logic [2:0]  dig_en_q, dig_en_d;

   logic        rise;
   logic [19:0] adj;

   function automatic logic [6:0] seg_decode(input logic [3:0] d);
      logic [6:0] s;
      case (d)
         4'd0:    s = 7'h3F;
         4'd1:    s = 7'h06;
         4'd2:    s = 7'h5B;
         4'd3:    s = 7'h4F;
         4'd4:    s = 7'h66;
         4'd5:    s = 7'h6D;
         4'd6:    s = 7'h7D;
         4'd7:    s = 7'h07;
         4'd8:    s = 7'h7F;
         4'd9:    s = 7'h6F;
         default: s = 7'h00;
      endcase
      return s;
   endfunction

   assign rise = load & ~load_q;

   // Add-3 correction on every BCD nibble before the shift.
   always_comb begin
      adj = shift_q;
      if (shift_q[11:8] >= 4'd5)  adj[11:8]  = shift_q[11:8] + 4'd3;
      if (shift_q[15:12] >= 4'd5) adj[15:12] = shift_q[15:12] + 4'd3;
      if (shift_q[19:16] >= 4'd5) adj[19:16] = shift_q[19:16] + 4'd3;
   end

   // Conversion FSM. A rise in any state restarts the conversion, so an
   // aborted value never reaches the display registers.
   always_comb begin
      state_d     = state_q;
      value_d     = value_q;
      shift_d     = shift_q;
      iter_d      = iter_q;
      disp_hund_d = disp_hund_q;
      disp_tens_d = disp_tens_q;
      disp_ones_d = disp_ones_q;
      if (rise) begin
         state_d = StConv;
         value_d = data_bus;
         shift_d = {12'b0, data_bus};
         iter_d  = 3'd0;
      end else begin
         case (state_q)
            StConv: begin
               shift_d = adj << 1;
               iter_d  = iter_q + 3'd1;
               if (iter_q == 3'd7) state_d = StCommit;
            end
            StCommit: begin
               disp_hund_d = shift_q[17:16];
               disp_tens_d = shift_q[15:12];
               disp_ones_d = shift_q[11:8];
               state_d     = StIdle;
            end
            default: state_d = StIdle;
         endcase
      end
   end

   // Free-running scan; seg/dig_en registered together from one index.
   always_comb begin
      refresh_cnt_d = refresh_cnt_q + 16'd1;
      idx_d         = idx_q;
      if (refresh_cnt_q == CntMax) begin
         refresh_cnt_d = 16'd0;
         idx_d         = (idx_q == 2'd2) ? 2'd0 : idx_q + 2'd1;
      end
      case (idx_q)
         2'd1: begin
            dig_en_d = 3'b010;
            seg_d    = (disp_hund_q == 2'd0 && disp_tens_q == 4'd0) ? 7'h00
                                                                   : seg_decode(disp_tens_q);
         end
         2'd2: begin
            dig_en_d = 3'b100;
            seg_d    = (disp_hund_q == 2'd0) ? 7'h00 : seg_decode({2'b00, disp_hund_q});
         end
         default: begin
            dig_en_d = 3'b001;
            seg_d    = seg_decode(disp_ones_q);
         end
      endcase
   end

   always_ff @(posedge fastClk or negedge rst) begin
      if (!rst) begin
         state_q       <= StIdle;
         load_q        <= 1'b0;
         value_q       <= 8'd0;
         shift_q       <= 20'd0;
         iter_q        <= 3'd0;
         disp_hund_q   <= 2'd0;
         disp_tens_q   <= 4'd0;
         disp_ones_q   <= 4'd0;
         refresh_cnt_q <= 16'd0;
         idx_q         <= 2'd0;
         seg_q         <= 7'h3F;
         dig_en_q      <= 3'b001;
      end else begin
         state_q       <= state_d;
         load_q        <= load;
         value_q       <= value_d;
         shift_q       <= shift_d;
         iter_q        <= iter_d;
         disp_hund_q   <= disp_hund_d;
         disp_tens_q   <= disp_tens_d;
         disp_ones_q   <= disp_ones_d;
         refresh_cnt_q <= refresh_cnt_d;
         idx_q         <= idx_d;
         seg_q         <= seg_d;
         dig_en_q      <= dig_en_d;
      end
   end

   assign value  = value_q;
   assign busy   = (state_q != StIdle);
   assign seg    = seg_q;
   assign dig_en = dig_en_q;

endmodule

// File: tb/tb_output_display.sv
module tb_output_display;

   logic       fastClk;
   logic       rst;
   logic       load;
   logic [7:0] data_bus;
   logic [7:0] value;
   logic       busy;
   logic [6:0] seg;
   logic [2:0] dig_en;

   int n_pass;
   int n_total;

   logic mon_en;
   logic saw_100;

   output_display #(.REFRESH_DIV(4)) dut (
      .fastClk  (fastClk),
      .rst      (rst),
      .load     (load),
      .data_bus (data_bus),
      .value    (value),
      .busy     (busy),
      .seg      (seg),
      .dig_en   (dig_en)
   );

   initial fastClk = 1'b0;
   always #5 fastClk = ~fastClk;

   // Flags any moment the aborted value 100 would show its hundreds digit.
   always @(negedge fastClk) begin
      if (mon_en && dig_en == 3'b100 && seg == 7'h06) saw_100 = 1'b1;
   end

   typedef struct {
      logic [7:0] data;
      logic [6:0] ones;
      logic [6:0] tens;
      logic [6:0] hund;
   } vec_t;

   vec_t vecs[7];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
   endtask

   task automatic wait_dig(input logic [2:0] target, output logic ok);
      int cnt;
      cnt = 0;
      while (dig_en !== target && cnt < 40) begin
         @(negedge fastClk);
         cnt++;
      end
      ok = (dig_en === target);
   endtask

   task automatic check_disp(input string name, input logic [6:0] e_ones,
                             input logic [6:0] e_tens, input logic [6:0] e_hund);
      logic ok;
      repeat (2) @(negedge fastClk);
      wait_dig(3'b001, ok);
      if (!ok) check({name, " ones-timeout"}, 32'(dig_en), 32'h1);
      else check({name, " ones"}, 32'(seg), 32'(e_ones));
      wait_dig(3'b010, ok);
      if (!ok) check({name, " tens-timeout"}, 32'(dig_en), 32'h2);
      else check({name, " tens"}, 32'(seg), 32'(e_tens));
      wait_dig(3'b100, ok);
      if (!ok) check({name, " hund-timeout"}, 32'(dig_en), 32'h4);
      else check({name, " hund"}, 32'(seg), 32'(e_hund));
   endtask

   // Load a byte with a single-cycle strobe; returns busy-high cycle count.
   task automatic do_load(input logic [7:0] d, output int bcnt);
      data_bus = d;
      load     = 1'b1;
      @(posedge fastClk);
      #1;
      load = 1'b0;
      check($sformatf("value after load %0d", d), 32'(value), 32'(d));
      bcnt = busy ? 1 : 0;
      for (int k = 0; k < 30; k++) begin
         @(posedge fastClk);
         #1;
         if (busy) bcnt++;
         else break;
      end
   endtask

   task automatic run_len(output logic [2:0] en, output int len);
      en  = dig_en;
      len = 0;
      while (dig_en === en && len < 20) begin
         @(negedge fastClk);
         len++;
      end
   endtask

   initial begin
      int bcnt;
      logic [2:0] en;
      int len;

      vecs[0] = '{data: 8'd42,  ones: 7'h5B, tens: 7'h66, hund: 7'h00};
      vecs[1] = '{data: 8'd255, ones: 7'h6D, tens: 7'h6D, hund: 7'h5B};
      vecs[2] = '{data: 8'd0,   ones: 7'h3F, tens: 7'h00, hund: 7'h00};
      vecs[3] = '{data: 8'd100, ones: 7'h3F, tens: 7'h3F, hund: 7'h06};
      vecs[4] = '{data: 8'd7,   ones: 7'h07, tens: 7'h00, hund: 7'h00};
      vecs[5] = '{data: 8'd19,  ones: 7'h6F, tens: 7'h06, hund: 7'h00};
      vecs[6] = '{data: 8'd208, ones: 7'h7F, tens: 7'h3F, hund: 7'h5B};

      n_pass   = 0;
      n_total  = 0;
      mon_en   = 1'b0;
      saw_100  = 1'b0;
      rst      = 1'b0;
      load     = 1'b0;
      data_bus = 8'h00;

      // Reset state
      repeat (3) @(negedge fastClk);
      check("reset dig_en", 32'(dig_en), 32'h1);
      check("reset seg", 32'(seg), 32'h3F);
      check("reset busy", 32'(busy), 32'h0);
      check("reset value", 32'(value), 32'h0);
      rst = 1'b1;

      // Scan stepping and slot length
      run_len(en, len);
      run_len(en, len);
      check("scan step1 en", 32'(en), 32'h2);
      check("scan step1 len", 32'(len), 32'd4);
      run_len(en, len);
      check("scan step2 en", 32'(en), 32'h4);
      check("scan step2 len", 32'(len), 32'd4);
      run_len(en, len);
      check("scan step3 en", 32'(en), 32'h1);
      check("scan step3 len", 32'(len), 32'd4);

      // Table-driven conversions
      for (int i = 0; i < 7; i++) begin
         do_load(vecs[i].data, bcnt);
         check($sformatf("busy cycles %0d", vecs[i].data), 32'(bcnt), 32'd9);
         check_disp($sformatf("disp %0d", vecs[i].data), vecs[i].ones, vecs[i].tens,
                    vecs[i].hund);
      end

      // Restart: 100 then 7 three cycles later
      @(posedge fastClk);
      #1;
      mon_en   = 1'b1;
      data_bus = 8'd100;
      load     = 1'b1;
      @(posedge fastClk);
      #1;
      load = 1'b0;
      bcnt = busy ? 1 : 0;
      for (int k = 0; k < 2; k++) begin
         @(posedge fastClk);
         #1;
         if (busy) bcnt++;
      end
      data_bus = 8'd7;
      load     = 1'b1;
      @(posedge fastClk);
      #1;
      load = 1'b0;
      check("restart value", 32'(value), 32'd7);
      if (busy) bcnt++;
      for (int k = 0; k < 30; k++) begin
         @(posedge fastClk);
         #1;
         if (busy) bcnt++;
         else break;
      end
      check("restart busy cycles", 32'(bcnt), 32'd12);
      check_disp("restart disp", 7'h07, 7'h00, 7'h00);
      mon_en = 1'b0;
      check("aborted 100 shown", 32'(saw_100), 32'h0);

      // Held load: one capture of the first-cycle value
      @(posedge fastClk);
      #1;
      data_bus = 8'd55;
      load     = 1'b1;
      @(posedge fastClk);
      #1;
      check("hold first value", 32'(value), 32'd55);
      bcnt = busy ? 1 : 0;
      for (int k = 1; k < 20; k++) begin
         data_bus = 8'(k * 13);
         @(posedge fastClk);
         #1;
         if (busy) bcnt++;
      end
      check("hold busy cycles", 32'(bcnt), 32'd9);
      check("hold value kept", 32'(value), 32'd55);
      load = 1'b0;
      check_disp("hold disp", 7'h6D, 7'h6D, 7'h00);

      // Asynchronous reset at CONV iteration 4
      @(posedge fastClk);
      #1;
      data_bus = 8'd200;
      load     = 1'b1;
      @(posedge fastClk);
      #1;
      load = 1'b0;
      repeat (4) @(posedge fastClk);
      #1;
      check("pre-reset busy", 32'(busy), 32'h1);
      rst = 1'b0;
      #1;
      check("async rst value", 32'(value), 32'h0);
      check("async rst busy", 32'(busy), 32'h0);
      check("async rst dig_en", 32'(dig_en), 32'h1);
      check("async rst seg", 32'(seg), 32'h3F);
      @(negedge fastClk);
      rst = 1'b1;
      check_disp("post-reset disp", 7'h3F, 7'h00, 7'h00);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

   // Global time limit so the bench always ends.
   initial begin
      #200000;
      $display("FAIL timeout: simulation time limit reached");
      $fatal(1);
   end

endmodule

// File: doc/output_display.md
# output_display

Downstream consumer of the eight-bit computer's output register: it captures the byte driven on the shared bus when the output-enable strobe rises. It converts that byte to three BCD digits with a sequential double-dabble engine and drives a multiplexed three-digit common-cathode 7-segment display. It runs on the same fast clock from which the CPU's slow clock is derived, so no synchronisers are needed on `load` or `data_bus`.

## Interface
- `REFRESH_DIV`, default 1024: fastClk cycles each digit stays enabled. Legal range is 1..65535.
- `fastClk`, in, 1: the single clock. All state updates on its rising edge.
- `rst`, in, 1: reset is asynchronous and active-low.
- `load`, in, 1: output-register enable strobe (`output_enable`/oi). Level signal.
- `data_bus`, in, 8: CPU bus value, sampled when a `load` rising edge is detected.
- `value`, out, 8: last captured byte.
- `busy`, out, 1: high while a conversion is in progress.
- `seg`, out, 7: segment drive `{g,f,e,d,c,b,a}`, active-high.
- `dig_en`, out, 3: one-hot digit enable, active-high. Bit 0 = ones, bit 1 = tens, bit 2 = hundreds.

## Operation
- **Edge detect:** `load_q` registers `load`. A rise is `load & ~load_q`. A level held high produces exactly one capture.
- **FSM states:**
  - IDLE: on rise, go to CONV. Capture `value <= data_bus`, load the shift register with `{12'b0, data_bus}`, set `iter <= 0`.
  - CONV: each cycle, first add 3 to every BCD nibble that is >= 5, then shift the 20-bit register left by 1. Increment `iter`. After the 8th shift, go to COMMIT.
  - COMMIT: copy the BCD nibbles (hundreds[1:0], tens[3:0], ones[3:0]) into the display registers, then go to IDLE.
- **Rise during CONV or COMMIT:** abort the current conversion. Recapture `data_bus` and restart CONV with `iter = 0`. The display registers are not updated for the aborted value.
- **Display registers** change only in COMMIT, so a partial result is never shown.
- **Leading-zero blanking:**
  - The hundreds digit is blank when hundreds == 0.
  - The tens digit is blank when hundreds == 0 and tens == 0.
  - The ones digit is never blank.
  - A blank digit drives `seg = 7'h00`; its `dig_en` bit still asserts in its slot.
- **Segment codes:** 0 = 3F, 1 = 06, 2 = 5B, 3 = 4F, 4 = 66, 5 = 6D, 6 = 7D, 7 = 07, 8 = 7F, 9 = 6F. Nibbles above 9 cannot occur; decode them to 00.
- **Scan:**
  - `refresh_cnt` counts 0..REFRESH_DIV-1 and wraps.
  - On the wrap cycle, the digit index advances ones → tens → hundreds → ones.
  - `seg` and `dig_en` are registered from the index and display registers. They change together, with no cycle where two digits are enabled.
  - The scan free-runs, independent of the FSM.
- **Reset values:**
  - FSM = IDLE, `value = 0`, `busy = 0`, `load_q = 0`.
  - Display registers = 0, so the display shows "0" on ones only.
  - Digit index = ones, `refresh_cnt = 0`, `dig_en = 3'b001`, `seg = 7'h3F`.
- **Reset asserted mid-conversion:** everything returns to the reset values immediately (asynchronously); the partial conversion is discarded.

## Timing
- **Edge N** (`load` sampled 1, `load_q` 0): `value` updates and `busy` goes 1, both visible after edge N.
- **Edges N+1..N+8:** the eight add-3/shift steps.
- **Edge N+9:** COMMIT. The display registers update and `busy` returns to 0.
  - `busy` is high for exactly 9 cycles.
  - New digits appear on `seg` at the next digit slot boundary, or within 1 cycle if the affected digit is currently enabled.
- **Restart:** a rise at edge M during CONV or COMMIT recaptures at M. `busy` stays high, and COMMIT occurs at M+9.
- **Scan period:** each `dig_en` bit is high for REFRESH_DIV consecutive cycles. The full scan takes 3×REFRESH_DIV cycles.
- **REFRESH_DIV = 1:** the digit advances every cycle.

## Test plan
- Reset with `rst = 0`, then release → `dig_en = 001`, `seg = 3F`, `busy = 0`, `value = 00`, with `dig_en` stepping 001 → 010 → 100 → 001.
- With REFRESH_DIV = 4, `data_bus = 42` and a `load` rise at edge N → `busy` high for edges N..N+8, low after N+9. Ones = 5B, tens = 66, hundreds blank (00). Each `dig_en` bit stays high for 4 cycles.
- `data_bus = 255` → digits 6D, 6D, 5B. Then `data_bus = 0` → ones 3F; tens and hundreds 00.
- `data_bus = 100` → ones 3F, tens 3F, hundreds 06 (interior zero not blanked). Then `data_bus = 7` → ones 07, tens and hundreds blank.
- Load 100, then a second rise with `data_bus = 7` three cycles later → 100 is never displayed, 7 is shown, and `busy` spans 12 cycles total.
- Hold `load` high for 20 cycles while `data_bus` changes → exactly one capture, of the first-cycle value. Then assert `rst` at CONV iteration 4 → all outputs return to their reset values asynchronously.
